// File: rtl/virtual_ow_pkg.sv
// Shared definitions for the emulated 1-Wire ROM layer: ROM command codes and FSM state encoding.
package virtual_ow_pkg;

  localparam logic [7:0] CMD_READ_ROM  = 8'h33;
  localparam logic [7:0] CMD_MATCH_ROM = 8'h55;
  localparam logic [7:0] CMD_SKIP_ROM  = 8'hCC;
  localparam logic [7:0] CMD_SEARCH    = 8'hF0;
  localparam logic [7:0] CMD_RESUME    = 8'hA5;
  localparam logic [7:0] CMD_OD_SKIP   = 8'h3C;
  localparam logic [7:0] CMD_OD_MATCH  = 8'h69;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CMD      = 3'd1,
    ST_READ_ROM = 3'd2,
    ST_MATCH    = 3'd3,
    ST_SRCH_BIT = 3'd4,
    ST_SRCH_CMP = 3'd5,
    ST_SRCH_DIR = 3'd6,
    ST_SELECTED = 3'd7
  } state_t;

endpackage

// File: rtl/virtual_ow_rom_layer.sv
// 1-Wire slave ROM-function layer: decodes ROM commands and emulates ROM_ID for read/match/search.
// Slot-driven: state advances one cycle after slotDone; txEn/txBit follow the registered state.
module virtual_ow_rom_layer
  import virtual_ow_pkg::*;
#(
  parameter logic [63:0] ROM_ID       = 64'h6A00_0000_1234_562D,
  parameter bit          EN_OVERDRIVE = 1'b1,
  parameter bit          EN_SEARCH    = 1'b1,
  parameter bit          EN_RESUME    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       busRst,
  input  logic       odBusRst,
  input  logic       slotDone,
  input  logic       rxBit,
  output logic       txEn,
  output logic       txBit,
  output logic       odMode,
  output logic       selected,
  output logic       romDone,
  output logic       resumeFlag,
  output logic [7:0] romCmd
);

  state_t      state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rom_cmd_q, rom_cmd_d;
  logic        disp_q, disp_d;
  logic        od_q, od_d;
  logic        sel_q, sel_d;
  logic        done_q, done_d;
  logic        rc_q, rc_d;
  logic        bus_reset;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 6'd0;
      shift_q   <= 8'h00;
      rom_cmd_q <= 8'h00;
      disp_q    <= 1'b0;
      od_q      <= 1'b0;
      sel_q     <= 1'b0;
      done_q    <= 1'b0;
      rc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      rom_cmd_q <= rom_cmd_d;
      disp_q    <= disp_d;
      od_q      <= od_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
      rc_q      <= rc_d;
    end
  end

  // An overdrive-length reset only counts once the bus is already in overdrive.
  assign bus_reset = busRst | (odBusRst & od_q);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rom_cmd_d = rom_cmd_q;
    disp_d    = disp_q;
    od_d      = od_q;
    sel_d     = sel_q;
    done_d    = 1'b0;
    rc_d      = rc_q;

    if (bus_reset) begin
      state_d   = ST_CMD;
      bit_cnt_d = 6'd0;
      sel_d     = 1'b0;
      disp_d    = 1'b0;
      if (busRst) od_d = 1'b0;
    end else begin
      case (state_q)
        ST_CMD: begin
          if (disp_q) begin
            disp_d    = 1'b0;
            bit_cnt_d = 6'd0;
            state_d   = ST_IDLE;
            case (rom_cmd_q)
              CMD_READ_ROM: begin
                state_d = ST_READ_ROM;
                rc_d    = 1'b0;
              end
              CMD_MATCH_ROM: state_d = ST_MATCH;
              CMD_SKIP_ROM: begin
                state_d = ST_SELECTED;
                rc_d    = 1'b0;
              end
              CMD_SEARCH: if (EN_SEARCH) state_d = ST_SRCH_BIT;
              CMD_RESUME: if (EN_RESUME && rc_q) state_d = ST_SELECTED;
              CMD_OD_SKIP: if (EN_OVERDRIVE) begin
                od_d    = 1'b1;
                rc_d    = 1'b0;
                state_d = ST_SELECTED;
              end
              CMD_OD_MATCH: if (EN_OVERDRIVE) begin
                od_d    = 1'b1;
                state_d = ST_MATCH;
              end
              default: state_d = ST_IDLE;
            endcase
          end else if (slotDone) begin
            shift_d   = {rxBit, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_q == 6'd7) begin
              rom_cmd_d = {rxBit, shift_q[7:1]};
              disp_d    = 1'b1;
              bit_cnt_d = 6'd0;
            end
          end
        end
        ST_READ_ROM: if (slotDone) begin
          if (bit_cnt_q == 6'd63) state_d = ST_SELECTED;
          else bit_cnt_d = bit_cnt_q + 6'd1;
        end
        ST_MATCH: if (slotDone) begin
          if (rxBit != ROM_ID[bit_cnt_q]) begin
            state_d = ST_IDLE;
            rc_d    = 1'b0;
          end else if (bit_cnt_q == 6'd63) begin
            state_d = ST_SELECTED;
            rc_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end
        ST_SRCH_BIT: if (slotDone) state_d = ST_SRCH_CMP;
        ST_SRCH_CMP: if (slotDone) state_d = ST_SRCH_DIR;
        ST_SRCH_DIR: if (slotDone) begin
          if (rxBit != ROM_ID[bit_cnt_q]) begin
            state_d = ST_IDLE;
            rc_d    = 1'b0;
          end else if (bit_cnt_q == 6'd63) begin
            state_d = ST_SELECTED;
            rc_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            state_d   = ST_SRCH_BIT;
          end
        end
        default: ;
      endcase
    end

    if (state_d == ST_SELECTED && state_q != ST_SELECTED) begin
      sel_d  = 1'b1;
      done_d = 1'b1;
    end
  end

  always_comb begin
    txEn  = 1'b0;
    txBit = 1'b0;
    case (state_q)
      ST_READ_ROM, ST_SRCH_BIT: begin
        txEn  = 1'b1;
        txBit = ROM_ID[bit_cnt_q];
      end
      ST_SRCH_CMP: begin
        txEn  = 1'b1;
        txBit = ~ROM_ID[bit_cnt_q];
      end
      default: ;
    endcase
  end

  assign odMode     = od_q;
  assign selected   = sel_q;
  assign romDone    = done_q;
  assign resumeFlag = rc_q;
  assign romCmd     = rom_cmd_q;

endmodule

// File: tb/tb_virtual_ow_rom_layer.sv
// Bench for virtual_ow_rom_layer: expected read-slot bits and romDone pulses are queued by the
// stimulus and consumed by a monitor; static levels are checked directly after each step.
module tb_virtual_ow_rom_layer;

  logic       clk = 1'b0;
  logic       rst, busRst, odBusRst, slotDone, rxBit;
  logic       txEn, txBit, odMode, selected, romDone, resumeFlag;
  logic [7:0] romCmd;

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] exp_id = 64'h6A00_0000_1234_562D;
  logic [63:0] bad_id;

  typedef struct packed {
    logic is_done;
    logic val;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;

  virtual_ow_rom_layer #(
    .ROM_ID(64'h6A00_0000_1234_562D),
    .EN_OVERDRIVE(1'b1),
    .EN_SEARCH(1'b1),
    .EN_RESUME(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .busRst(busRst),
    .odBusRst(odBusRst),
    .slotDone(slotDone),
    .rxBit(rxBit),
    .txEn(txEn),
    .txBit(txBit),
    .odMode(odMode),
    .selected(selected),
    .romDone(romDone),
    .resumeFlag(resumeFlag),
    .romCmd(romCmd)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic consume(input ev_t got);
    ev_t e;
    n_chk++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got done=%0b bit=%0b expected nothing", got.is_done, got.val);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        n_err++;
        $display("FAIL event @%0t: got done=%0b bit=%0b expected done=%0b bit=%0b",
                 $time, got.is_done, got.val, e.is_done, e.val);
      end
    end
  endtask

  // A read slot is observed when the master finishes it while this block drives.
  always @(negedge clk) begin
    if (!rst) begin
      if (slotDone && txEn && !busRst && !odBusRst) consume('{is_done: 1'b0, val: txBit});
      if (romDone) consume('{is_done: 1'b1, val: 1'b0});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_slot(input logic b);
    slotDone = 1'b1;
    rxBit    = b;
    tick();
    slotDone = 1'b0;
    rxBit    = 1'b0;
    tick();
  endtask

  task automatic bus_rst();
    busRst = 1'b1;
    tick();
    busRst = 1'b0;
    tick();
  endtask

  task automatic od_rst();
    odBusRst = 1'b1;
    tick();
    odBusRst = 1'b0;
    tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) do_slot(v[i]);
  endtask

  task automatic push_tx(input logic b);
    exp_q.push_back('{is_done: 1'b0, val: b});
  endtask

  task automatic push_done();
    exp_q.push_back('{is_done: 1'b1, val: 1'b0});
  endtask

  initial begin
    rst = 1'b1; busRst = 1'b0; odBusRst = 1'b0; slotDone = 1'b0; rxBit = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_txEn", txEn, 0);
    chk("rst_txBit", txBit, 0);
    chk("rst_odMode", odMode, 0);
    chk("rst_selected", selected, 0);
    chk("rst_romDone", romDone, 0);
    chk("rst_resumeFlag", resumeFlag, 0);
    chk("rst_romCmd", romCmd, 8'h00);
    send_byte(8'hCC);
    chk("idle_ignores_slots", romCmd, 8'h00);

    // Read ROM: 64 driven bits then SELECTED
    bus_rst();
    send_byte(8'h33);
    chk("read_romCmd", romCmd, 8'h33);
    chk("read_txEn", txEn, 1);
    for (int i = 0; i < 64; i++) push_tx(exp_id[i]);
    push_done();
    for (int i = 0; i < 64; i++) do_slot(1'b1);
    chk("read_selected", selected, 1);
    chk("read_txEn_after", txEn, 0);
    send_byte(8'h55);
    chk("selected_ignores_slots", romCmd, 8'h33);

    // Match ROM then Resume
    bus_rst();
    chk("busrst_clears_selected", selected, 0);
    push_done();
    send_byte(8'h55);
    chk("match_txEn", txEn, 0);
    for (int i = 0; i < 64; i++) do_slot(exp_id[i]);
    chk("match_selected", selected, 1);
    chk("match_rc", resumeFlag, 1);
    bus_rst();
    chk("rc_kept_over_busrst", resumeFlag, 1);
    push_done();
    send_byte(8'hA5);
    chk("resume_selected", selected, 1);
    chk("resume_rc", resumeFlag, 1);

    // Match with bit 10 flipped: drops to IDLE, rest of the ID must not select
    bus_rst();
    send_byte(8'h55);
    bad_id = exp_id ^ (64'd1 << 10);
    for (int i = 0; i < 64; i++) do_slot(bad_id[i]);
    chk("badmatch_selected", selected, 0);
    chk("badmatch_rc", resumeFlag, 0);
    bus_rst();
    send_byte(8'hA5);
    chk("resume_without_rc", selected, 0);

    // Search ROM, full pass
    bus_rst();
    send_byte(8'hF0);
    for (int i = 0; i < 64; i++) begin
      push_tx(exp_id[i]);
      push_tx(~exp_id[i]);
    end
    push_done();
    for (int i = 0; i < 64; i++) begin
      do_slot(1'b1);
      do_slot(1'b1);
      do_slot(exp_id[i]);
    end
    chk("search_selected", selected, 1);
    chk("search_rc", resumeFlag, 1);

    // Search lost at bit 0 (ID bit 0 is 1, master writes 0)
    bus_rst();
    send_byte(8'hF0);
    push_tx(1'b1);
    push_tx(1'b0);
    do_slot(1'b1);
    do_slot(1'b1);
    do_slot(1'b0);
    chk("search_lost_rc", resumeFlag, 0);
    chk("search_lost_txEn", txEn, 0);
    for (int i = 0; i < 6; i++) do_slot(1'b1);
    chk("search_lost_selected", selected, 0);

    // odBusRst with odMode=0 is ignored: still IDLE, so a command is not received
    od_rst();
    send_byte(8'hCC);
    chk("odrst_ignored", romCmd, 8'hF0);

    // Overdrive Skip, overdrive reset, then standard reset
    bus_rst();
    push_done();
    send_byte(8'h3C);
    chk("odskip_odMode", odMode, 1);
    chk("odskip_selected", selected, 1);
    od_rst();
    chk("odrst_keeps_od", odMode, 1);
    chk("odrst_clears_sel", selected, 0);
    push_done();
    send_byte(8'hCC);
    chk("skip_after_odrst", selected, 1);
    bus_rst();
    chk("busrst_clears_od", odMode, 0);

    // Overdrive Match
    push_done();
    send_byte(8'h69);
    chk("odmatch_odMode", odMode, 1);
    for (int i = 0; i < 64; i++) do_slot(exp_id[i]);
    chk("odmatch_rc", resumeFlag, 1);
    bus_rst();

    // busRst coincident with slotDone at READ_ROM bit 30
    send_byte(8'h33);
    for (int i = 0; i < 30; i++) push_tx(exp_id[i]);
    for (int i = 0; i < 30; i++) do_slot(1'b1);
    busRst   = 1'b1;
    slotDone = 1'b1;
    tick();
    busRst   = 1'b0;
    slotDone = 1'b0;
    tick();
    chk("coincident_txEn", txEn, 0);
    chk("coincident_rc_cleared_by_33", resumeFlag, 0);
    send_byte(8'h33);
    chk("coincident_cmd_aligned", romCmd, 8'h33);
    for (int i = 0; i < 64; i++) push_tx(exp_id[i]);
    push_done();
    for (int i = 0; i < 64; i++) do_slot(1'b0);
    chk("reread_selected", selected, 1);

    // Unknown code
    bus_rst();
    send_byte(8'h99);
    chk("unknown_romCmd", romCmd, 8'h99);
    chk("unknown_selected", selected, 0);
    send_byte(8'hCC);
    chk("unknown_goes_idle", romCmd, 8'h99);

    tick();
    tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
